// File: rtl/tlul_m1_sched.sv
// Request scheduler for an M:1 TL-UL host socket.
//
// Chooses which host may present its A-channel request to the shared device path.
// The choice is weighted round-robin, and a stalled offer is held until it is
// accepted. Outstanding transactions are counted per host from the A accepts and
// D responses, and a host at MaxOut outstanding is not offered.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_i            per-host A-channel valid
//   weight_i         per-host burst weight, 4 bits per host (0 treated as 1)
//   ready_i          device-side a_ready
//   valid_o, idx_o   arbitrated request valid and the selected host index
//   gnt_o            one-hot per-host a_ready
//   rsp_valid_i      device D-channel valid
//   rsp_ready_i      d_ready of the host being responded to
//   rsp_idx_i        host index of the response
//   idle_o           no transaction outstanding on any host
//   err_o            sticky protocol error (counter underflow, bad response index)
module tlul_m1_sched #(
  parameter int unsigned M      = 4,
  parameter int unsigned MaxOut = 2,
  localparam int unsigned IdxW  = $clog2(M),
  localparam int unsigned CntW  = $clog2(MaxOut + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [M-1:0]      req_i,
  input  logic [M*4-1:0]    weight_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o,
  output logic [M-1:0]      gnt_o,
  input  logic              rsp_valid_i,
  input  logic              rsp_ready_i,
  input  logic [IdxW-1:0]   rsp_idx_i,
  output logic              idle_o,
  output logic              err_o
);

  logic [CntW-1:0] cnt_q [M];
  logic [CntW-1:0] cnt_d [M];
  logic [IdxW-1:0] ptr_q, ptr_d, last_q, last_d, hold_idx_q, hold_idx_d;
  logic [3:0]      burst_q, burst_d;
  logic            hold_q, hold_d, err_q, err_d;

  logic [M-1:0]    elig, inc, dec;
  logic [IdxW-1:0] sel_idx, cand;
  logic            found, accept, rsp_fire, rsp_bad, all_zero;
  logic [3:0]      w_raw, w_eff;
  logic [4:0]      burst_inc;

  always_comb begin
    for (int unsigned i = 0; i < M; i++) begin
      elig[i] = req_i[i] & (cnt_q[i] < CntW'(MaxOut));
    end
  end

  // A held offer wins while its host stays eligible; otherwise scan from ptr.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (hold_q && elig[hold_idx_q]) begin
      sel_idx = hold_idx_q;
      found   = 1'b1;
    end
    for (int unsigned off = 0; off < M; off++) begin
      cand = IdxW'((32'(ptr_q) + off) % M);
      if (!found && elig[cand]) begin
        sel_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign valid_o = ~rst_i & found;
  assign idx_o   = rst_i ? '0 : sel_idx;
  assign accept  = valid_o & ready_i;

  always_comb begin
    for (int unsigned i = 0; i < M; i++) begin
      gnt_o[i] = accept & (sel_idx == IdxW'(i));
    end
  end

  // Weighted round-robin pointer update.
  assign w_raw     = weight_i[32'(sel_idx)*4 +: 4];
  assign w_eff     = (w_raw == 4'd0) ? 4'd1 : w_raw;
  assign burst_inc = {1'b0, burst_q} + 5'd1;

  always_comb begin
    ptr_d   = ptr_q;
    burst_d = burst_q;
    last_d  = last_q;
    if (accept) begin
      last_d = sel_idx;
      if ((sel_idx == last_q) && (burst_inc < {1'b0, w_eff})) begin
        burst_d = burst_inc[3:0];
      end else if ((sel_idx != last_q) && (w_eff > 4'd1)) begin
        ptr_d   = sel_idx;
        burst_d = 4'd1;
      end else begin
        ptr_d   = (sel_idx == IdxW'(M - 1)) ? '0 : sel_idx + IdxW'(1);
        burst_d = 4'd0;
      end
    end
  end

  // Re-arming the hold every stalled cycle also drops it when its host goes ineligible.
  assign hold_d     = valid_o & ~ready_i;
  assign hold_idx_d = sel_idx;

  assign rsp_fire = rsp_valid_i & rsp_ready_i;
  assign rsp_bad  = rsp_fire & (32'(rsp_idx_i) >= M);

  always_comb begin
    for (int unsigned i = 0; i < M; i++) begin
      inc[i] = accept & (sel_idx == IdxW'(i));
      dec[i] = rsp_fire & ~rsp_bad & (rsp_idx_i == IdxW'(i));
    end
  end

  always_comb begin
    err_d = err_q | rsp_bad;
    for (int unsigned i = 0; i < M; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CntW'(1);
        end
      end
    end
  end

  always_comb begin
    all_zero = 1'b1;
    for (int unsigned i = 0; i < M; i++) begin
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
  end

  assign idle_o = rst_i | all_zero;
  assign err_o  = ~rst_i & err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < M; i++) cnt_q[i] <= '0;
      ptr_q      <= '0;
      last_q     <= '0;
      burst_q    <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < M; i++) cnt_q[i] <= cnt_d[i];
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_tlul_m1_sched.sv
// Self-checking bench for tlul_m1_sched (M=4, MaxOut=2), plus an M=3 instance
// for the out-of-range response index case.
module tb_tlul_m1_sched;

  localparam int MAXOUT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [15:0] weight;
  logic       ready, valid;
  logic [1:0] idx;
  logic [3:0] gnt;
  logic       rsp_valid, rsp_ready;
  logic [1:0] rsp_idx;
  logic       idle, err;

  logic [2:0]  req3;
  logic [11:0] weight3;
  logic        ready3, valid3, rsp_valid3, rsp_ready3, idle3, err3;
  logic [1:0]  idx3, rsp_idx3;
  logic [2:0]  gnt3;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int m_cnt[4];
  int m_ptr, m_burst, m_last, m_hidx, m_sel;
  bit m_hold, m_err;
  bit e_valid, e_idle, e_err;
  int e_idx;
  logic [3:0] e_gnt;

  always #5 clk = ~clk;

  tlul_m1_sched #(.M(4), .MaxOut(MAXOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .weight_i(weight), .ready_i(ready),
    .valid_o(valid), .idx_o(idx), .gnt_o(gnt), .rsp_valid_i(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_idx_i(rsp_idx), .idle_o(idle), .err_o(err)
  );

  tlul_m1_sched #(.M(3), .MaxOut(MAXOUT)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .weight_i(weight3), .ready_i(ready3),
    .valid_o(valid3), .idx_o(idx3), .gnt_o(gnt3), .rsp_valid_i(rsp_valid3),
    .rsp_ready_i(rsp_ready3), .rsp_idx_i(rsp_idx3), .idle_o(idle3), .err_o(err3)
  );

  // Expected outputs for the current inputs and model state.
  task automatic model_comb();
    bit el[4];
    bit found;
    int c;
    found = 0;
    m_sel = 0;
    for (int i = 0; i < 4; i++) el[i] = req[i] && (m_cnt[i] < MAXOUT);
    if (m_hold && el[m_hidx]) begin
      found = 1;
      m_sel = m_hidx;
    end
    for (int off = 0; off < 4; off++) begin
      c = (m_ptr + off) % 4;
      if (!found && el[c]) begin
        found = 1;
        m_sel = c;
      end
    end
    e_valid = found && !rst;
    e_idx   = e_valid ? m_sel : 0;
    e_gnt   = (e_valid && ready) ? (4'b0001 << m_sel) : 4'b0000;
    e_idle  = 1;
    for (int i = 0; i < 4; i++) if (m_cnt[i] != 0) e_idle = 0;
    e_err   = m_err;
    if (rst) begin
      e_idle = 1;
      e_err  = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_commit();
    bit acc;
    int w;
    acc = e_valid && ready;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_ptr = 0; m_burst = 0; m_last = 0; m_hold = 0; m_hidx = 0; m_err = 0;
      return;
    end
    if (acc) begin
      w = int'(weight[m_sel*4 +: 4]);
      if (w == 0) w = 1;
      if (m_sel == m_last && m_burst + 1 < w) m_burst++;
      else if (m_sel != m_last && w > 1) begin
        m_ptr = m_sel;
        m_burst = 1;
      end else begin
        m_ptr = (m_sel + 1) % 4;
        m_burst = 0;
      end
      m_last = m_sel;
    end
    m_hold = e_valid && !ready;
    m_hidx = m_sel;
    for (int i = 0; i < 4; i++) begin
      bit inc, dec;
      inc = acc && (m_sel == i);
      dec = rsp_valid && rsp_ready && (int'(rsp_idx) == i);
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err = 1;
        else m_cnt[i]--;
      end
    end
  endtask

  task automatic tick();
    model_comb();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = 0; ready = 0; rsp_valid = 0; rsp_ready = 1; rsp_idx = 0;
    weight = 16'h1111;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 4'hf; ready = 1; weight = 16'h1111;
    rsp_valid = 0; rsp_ready = 1; rsp_idx = 0;
    #2;
    n_total++;
    if ({valid, gnt, idx, idle, err} !== {1'b0, 4'b0, 2'b0, 1'b1, 1'b0})
      $display("FAIL reset_outputs valid=%b gnt=%b idx=%0d idle=%b err=%b exp 0/0000/0/1/0",
               valid, gnt, idx, idle, err);
    else n_pass++;
    tick();
    rst = 0;
  endtask

  task automatic test_rr_order();
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [3:0] exp;
    do_reset();
    req = 4'hf; ready = 1;
    for (int c = 0; c < 8; c++) begin
      rsp_valid = (c > 0);
      rsp_idx   = (c > 0) ? 2'(order[c-1]) : 2'd0;
      #2;
      exp = 4'b0001 << order[c];
      n_total++;
      if (gnt !== exp) $display("FAIL rr_order cycle %0d gnt=%b exp=%b", c, gnt, exp);
      else n_pass++;
      tick();
    end
    req = 0; rsp_valid = 1; rsp_idx = 2'd3;
    tick();
    rsp_valid = 0;
    #2;
    n_total++;
    if (idle !== 1'b1) $display("FAIL rr_idle_end idle=%b exp=1", idle);
    else n_pass++;
    tick();
  endtask

  task automatic test_weighted();
    int order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic [3:0] exp;
    do_reset();
    weight = 16'h1113; req = 4'b0011; ready = 1;
    for (int c = 0; c < 8; c++) begin
      rsp_valid = (c > 0);
      rsp_idx   = (c > 0) ? 2'(order[c-1]) : 2'd0;
      #2;
      exp = 4'b0001 << order[c];
      n_total++;
      if (gnt !== exp) $display("FAIL wrr_order cycle %0d gnt=%b exp=%b", c, gnt, exp);
      else n_pass++;
      tick();
    end
    req = 0; rsp_valid = 1; rsp_idx = 2'd1;
    tick();
    rsp_valid = 0;
  endtask

  task automatic test_maxout();
    logic [3:0] exp_g[6] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    do_reset();
    req = 4'b0100; ready = 1;
    for (int c = 0; c < 6; c++) begin
      rsp_valid = (c == 3);
      rsp_idx   = 2'd2;
      #2;
      n_total++;
      if (gnt !== exp_g[c] || valid !== (exp_g[c] != 0))
        $display("FAIL maxout cycle %0d valid=%b gnt=%b exp gnt=%b", c, valid, gnt, exp_g[c]);
      else n_pass++;
      tick();
    end
    rsp_valid = 0;
  endtask

  task automatic test_stall();
    do_reset();
    req = 4'b0010; ready = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req = 4'b0011;
      #2;
      n_total++;
      if (valid !== 1'b1 || idx !== 2'd1 || gnt !== 4'b0)
        $display("FAIL stall_hold cycle %0d valid=%b idx=%0d gnt=%b exp 1/1/0000",
                 c, valid, idx, gnt);
      else n_pass++;
      tick();
    end
    ready = 1;
    #2;
    n_total++;
    if (gnt !== 4'b0010) $display("FAIL stall_release gnt=%b exp=0010", gnt);
    else n_pass++;
    tick();
    #2;
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL stall_next gnt=%b exp=0001", gnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_counters_err();
    do_reset();
    req = 4'b1000; ready = 1;
    for (int c = 0; c < 3; c++) begin
      rsp_valid = (c == 1);
      rsp_idx   = 2'd3;
      #2;
      n_total++;
      if (gnt !== 4'b1000) $display("FAIL same_cycle cycle %0d gnt=%b exp=1000", c, gnt);
      else n_pass++;
      tick();
    end
    rsp_valid = 0;
    #2;
    n_total++;
    if (valid !== 1'b0) $display("FAIL same_cycle_limit valid=%b exp=0", valid);
    else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL err_before err=%b exp=0", err);
    else n_pass++;
    req = 0; rsp_valid = 1; rsp_idx = 2'd0;
    tick();
    rsp_valid = 0;
    #2;
    n_total++;
    if (err !== 1'b1 || idle !== 1'b0)
      $display("FAIL underflow_err err=%b idle=%b exp 1/0", err, idle);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (err !== 1'b1) $display("FAIL err_sticky err=%b exp=1", err);
    else n_pass++;
    rsp_valid3 = 1; rsp_idx3 = 2'd3;
    #1;
    n_total++;
    if (err3 !== 1'b0) $display("FAIL m3_err_before err=%b exp=0", err3);
    else n_pass++;
    tick();
    rsp_valid3 = 0;
    #2;
    n_total++;
    if (err3 !== 1'b1) $display("FAIL m3_bad_idx err=%b exp=1", err3);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_g[3] = '{4'b0001, 4'b0010, 4'b0001};
    do_reset();
    req = 4'b0011; ready = 1;
    for (int c = 0; c < 3; c++) begin
      rsp_valid = (c == 2);
      rsp_idx   = 2'd3;
      #2;
      n_total++;
      if (gnt !== exp_g[c]) $display("FAIL pre_reset cycle %0d gnt=%b exp=%b", c, gnt, exp_g[c]);
      else n_pass++;
      tick();
    end
    rsp_valid = 0; rst = 1;
    #2;
    n_total++;
    if ({valid, gnt, idx, idle, err} !== {1'b0, 4'b0, 2'b0, 1'b1, 1'b0})
      $display("FAIL mid_reset valid=%b gnt=%b idx=%0d idle=%b err=%b exp 0/0000/0/1/0",
               valid, gnt, idx, idle, err);
    else n_pass++;
    tick();
    rst = 0;
    #2;
    n_total++;
    if (gnt !== 4'b0001 || idle !== 1'b1 || err !== 1'b0)
      $display("FAIL post_reset gnt=%b idle=%b err=%b exp 0001/1/0", gnt, idle, err);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int h;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 40 == 0) weight = 16'($urandom);
      req       = 4'($urandom);
      ready     = ($urandom % 3) != 0;
      h         = $urandom_range(0, 3);
      rsp_valid = (m_cnt[h] > 0) && ($urandom % 2 == 1);
      rsp_ready = ($urandom % 4) != 0;
      rsp_idx   = 2'(h);
      #2;
      model_comb();
      n_total++;
      if (valid !== e_valid || gnt !== e_gnt || (e_valid && idx !== 2'(e_idx)))
        $display("FAIL random cycle %0d valid=%b idx=%0d gnt=%b exp %b/%0d/%b",
                 c, valid, idx, gnt, e_valid, e_idx, e_gnt);
      else n_pass++;
      n_total++;
      if (idle !== e_idle || err !== e_err)
        $display("FAIL random_status cycle %0d idle=%b err=%b exp %b/%b",
                 c, idle, err, e_idle, e_err);
      else n_pass++;
      tick();
    end
    rsp_valid = 0;
  endtask

  initial begin
    req3 = 0; weight3 = 12'h111; ready3 = 1;
    rsp_valid3 = 0; rsp_ready3 = 1; rsp_idx3 = 0;
    test_reset();
    test_rr_order();
    test_weighted();
    test_maxout();
    test_stall();
    test_counters_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tlul_m1_sched.md
Name: tlul_m1_sched

Overview:
- Request scheduler for an M:1 TL-UL host socket.
- Selects which host port may present its A-channel request to the shared device path, using weighted round-robin.
- Tracks outstanding (un-responded) transactions per host from A/D handshakes and throttles any host at its limit.
- Sits between the host-side FIFOs and the device-side FIFO; drives per-host a_ready (grant) and the arbitrated index used to mux request data.

Parameters:
- M, 4: number of host ports; 2..15.
- MaxOut, 2: maximum outstanding transactions per host; 1..15.
- IdxW, $clog2(M): width of host index (localparam).
- CntW, $clog2(MaxOut+1): width of outstanding counters (localparam).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  M  per-host A-channel valid.
- weight_i  in  M*4  per-host burst weight, bits [i*4+:4]; 0 is treated as 1.
- ready_i  in  1  device-side a_ready.
- valid_o  out  1  arbitrated request valid toward device.
- idx_o  out  IdxW  selected host index; meaningful only when valid_o=1.
- gnt_o  out  M  one-hot per-host a_ready (accept).
- rsp_valid_i  in  1  device D-channel valid.
- rsp_ready_i  in  1  selected host d_ready.
- rsp_idx_i  in  IdxW  host index decoded from d_source low bits.
- idle_o  out  1  no transaction outstanding on any host.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset:
  - Counters, ptr, burst count, hold and err are cleared on the clock edge with rst_i=1.
  - While rst_i=1: valid_o=0, gnt_o=0, idx_o=0, idle_o=1, err_o=0.
- Eligibility: elig[i] = req_i[i] & (cnt[i] < MaxOut).
- Selection (combinational, zero latency):
  - If hold_q=1 and elig[hold_idx_q]=1, select hold_idx_q.
  - Otherwise select the first eligible index scanning ptr, ptr+1, … modulo M.
  - valid_o = |elig; idx_o = selected index.
- Grant:
  - gnt_o[idx_o] = valid_o & ready_i; all other gnt_o bits are 0.
  - gnt_o is always one-hot or zero.
  - Accept event = valid_o & ready_i.
- Stability:
  - If valid_o=1 and ready_i=0, set hold_q=1 and hold_idx_q=idx_o, so the offer is not switched to another host while stalled.
  - hold_q clears on accept.
  - hold_q also clears if the held host becomes ineligible; no error is flagged for this.
- Weighted round-robin, updated on accept from host k:
  - Let w = max(weight_i[k],1).
  - If k==last_q and burst_q+1 < w: ptr stays k and burst_q increments.
  - Else if k!=last_q and w>1: ptr=k and burst_q=1.
  - Else: ptr=(k+1) mod M and burst_q=0.
  - last_q=k in all cases.
  - ptr wraps from M-1 to 0.
  - No update without an accept.
- Outstanding counters:
  - inc[i] = accept & idx_o==i.
  - dec[i] = rsp_valid_i & rsp_ready_i & rsp_idx_i==i.
  - inc only: +1. dec only: -1. Both in the same cycle: unchanged.
  - Counters never exceed MaxOut because eligibility blocks the increment.
- Error cases, each sets err_o (sticky until reset) and leaves counters unchanged:
  - dec on a counter at 0.
  - rsp_valid_i & rsp_ready_i with rsp_idx_i >= M.
- idle_o = all cnt==0, registered-state based (combinational from counters).
- Throughput: one accept per cycle maximum; no bubble between back-to-back accepts from the same or different hosts.

Test Plan:
- M=4, weights all 1, req_i=4'b1111, ready_i=1 for 8 cycles, responses returned immediately → grant order 0,1,2,3,0,1,2,3; idle_o=1 at end.
- weight_i={1,1,1,3} (host0=3), req_i=4'b0011 constant, immediate responses → grant order 0,0,0,1,0,0,0,1.
- MaxOut=2, host2 requests alone, no responses → two accepts, then valid_o=0 while req_i[2]=1. One response with rsp_idx_i=2 → valid_o=1 next cycle; cnt[2] goes 2→1→2.
- ready_i=0 for 3 cycles while host1 is offered (idx_o=1), host0 raising req mid-stall → idx_o stays 1 throughout. ready_i=1 → gnt_o=4'b0010, then host0 granted next.
- Same-cycle accept and response for host3 at cnt=1 → cnt stays 1. A response for host0 at cnt=0 → err_o=1 and stays 1. rsp_idx_i=3 with M=3 → err_o=1.
- Assert rst_i mid-traffic with cnt={2,1,0,0} → next cycle: counters 0, ptr 0, idle_o=1, err_o=0, gnt_o=0 during reset.
